// File: rtl/alu_sequencer.sv
// Command sequencer in front of the combinational ALU: SINGLE op, shift-by-N, 8x8 multiply (low byte), one ALU op per clock.
// Latency: N ALU cycles after the accept edge (0 for reserved commands and zero shifts); response held in DONE until RspReady.
module alu_sequencer #(
   parameter int             W     = 8,
   parameter int             Ops   = 4,
   parameter logic [Ops-1:0] OpAdd = Ops'(0),
   parameter logic [Ops-1:0] OpLsh = Ops'(6),
   parameter logic [Ops-1:0] OpRsh = Ops'(7)
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic           ReqValid,
   output logic           ReqReady,
   input  logic [2:0]     ReqCmd,
   input  logic [Ops-1:0] ReqAluOp,
   input  logic [W-1:0]   ReqA,
   input  logic [W-1:0]   ReqB,
   output logic [Ops-1:0] AluOp,
   output logic [W-1:0]   AluA,
   output logic [W-1:0]   AluB,
   input  logic [W-1:0]   AluOut,
   output logic           RspValid,
   input  logic           RspReady,
   output logic [W-1:0]   RspData,
   output logic           RspErr
);

   localparam logic [2:0] CMD_SINGLE = 3'd0;
   localparam logic [2:0] CMD_SHL    = 3'd1;
   localparam logic [2:0] CMD_SHR    = 3'd2;
   localparam logic [2:0] CMD_MUL    = 3'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SINGLE,
      S_SHIFT,
      S_MUL_ADD,
      S_MUL_LSH,
      S_MUL_RSH,
      S_DONE
   } state_e;

   state_e         state_q, state_d;
   logic [Ops-1:0] op_q, op_d;
   // a_q: operand A / shift working value / multiplicand; b_q: operand B / multiplier
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   acc_q, acc_d;
   logic [3:0]     cnt_q, cnt_d;
   logic           dir_q, dir_d;
   logic [W-1:0]   rsp_data_q, rsp_data_d;
   logic           rsp_err_q, rsp_err_d;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         dir_q      <= 1'b0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         dir_q      <= dir_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      dir_d      = dir_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      AluOp      = '0;
      AluA       = '0;
      AluB       = '0;

      case (state_q)
         S_IDLE: begin
            if (ReqValid) begin
               op_d      = ReqAluOp;
               a_d       = ReqA;
               b_d       = ReqB;
               acc_d     = '0;
               cnt_d     = '0;
               dir_d     = 1'b0;
               rsp_err_d = 1'b0;
               case (ReqCmd)
                  CMD_SINGLE: state_d = S_SINGLE;
                  CMD_SHL, CMD_SHR: begin
                     dir_d = (ReqCmd == CMD_SHR);
                     cnt_d = {1'b0, ReqB[2:0]};
                     if (ReqB[2:0] == 3'd0) begin
                        rsp_data_d = ReqA;
                        state_d    = S_DONE;
                     end else begin
                        state_d = S_SHIFT;
                     end
                  end
                  CMD_MUL: begin
                     cnt_d   = 4'd8;
                     state_d = ReqB[0] ? S_MUL_ADD : S_MUL_LSH;
                  end
                  default: begin
                     rsp_data_d = '0;
                     rsp_err_d  = 1'b1;
                     state_d    = S_DONE;
                  end
               endcase
            end
         end
         S_SINGLE: begin
            AluOp      = op_q;
            AluA       = a_q;
            AluB       = b_q;
            rsp_data_d = AluOut;
            state_d    = S_DONE;
         end
         S_SHIFT: begin
            AluOp = dir_q ? OpRsh : OpLsh;
            AluA  = a_q;
            a_d   = AluOut;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               rsp_data_d = AluOut;
               state_d    = S_DONE;
            end
         end
         S_MUL_ADD: begin
            AluOp   = OpAdd;
            AluA    = acc_q;
            AluB    = a_q;
            acc_d   = AluOut;
            state_d = S_MUL_LSH;
         end
         S_MUL_LSH: begin
            AluOp   = OpLsh;
            AluA    = a_q;
            a_d     = AluOut;
            state_d = S_MUL_RSH;
         end
         S_MUL_RSH: begin
            AluOp = OpRsh;
            AluA  = b_q;
            b_d   = AluOut;
            cnt_d = cnt_q - 4'd1;
            // The freshly shifted multiplier LSB decides whether the next iteration adds.
            if (cnt_q == 4'd1) begin
               rsp_data_d = acc_q;
               state_d    = S_DONE;
            end else begin
               state_d = AluOut[0] ? S_MUL_ADD : S_MUL_LSH;
            end
         end
         S_DONE: begin
            if (RspReady) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ReqReady = Reset && (state_q == S_IDLE);
   assign RspValid = (state_q == S_DONE);
   assign RspData  = rsp_data_q;
   assign RspErr   = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU model.
module tb_alu_sequencer;
   localparam int W = 8;
   localparam int Ops = 4;
   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                          OP_XOR = 4'd4, OP_NOT = 4'd5, OP_LSH = 4'd6, OP_RSH = 4'd7;
   localparam logic [2:0] C_SINGLE = 3'd0, C_SHL = 3'd1, C_SHR = 3'd2, C_MUL = 3'd3;

   logic           Clk = 1'b0;
   logic           Reset;
   logic           ReqValid;
   logic           ReqReady;
   logic [2:0]     ReqCmd;
   logic [Ops-1:0] ReqAluOp;
   logic [W-1:0]   ReqA, ReqB;
   logic [Ops-1:0] AluOp;
   logic [W-1:0]   AluA, AluB, AluOut;
   logic           RspValid, RspReady;
   logic [W-1:0]   RspData;
   logic           RspErr;

   alu_sequencer #(.W(W), .Ops(Ops)) dut (
      .Clk(Clk), .Reset(Reset),
      .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqCmd(ReqCmd), .ReqAluOp(ReqAluOp),
      .ReqA(ReqA), .ReqB(ReqB),
      .AluOp(AluOp), .AluA(AluA), .AluB(AluB), .AluOut(AluOut),
      .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData), .RspErr(RspErr)
   );

   always #5 Clk = ~Clk;

   always_comb begin
      AluOut = '0;
      case (AluOp)
         OP_ADD: AluOut = AluA + AluB;
         OP_SUB: AluOut = AluA - AluB;
         OP_AND: AluOut = AluA & AluB;
         OP_OR:  AluOut = AluA | AluB;
         OP_XOR: AluOut = AluA ^ AluB;
         OP_NOT: AluOut = ~AluA;
         OP_LSH: AluOut = AluA << 1;
         OP_RSH: AluOut = AluA >> 1;
         default: AluOut = '0;
      endcase
   end

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] data;
      logic       err;
      int         at_edge;
      string      name;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   bit   in_rsp = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge Clk) begin
      if (!Reset) begin
         in_rsp = 1'b0;
      end else if (RspValid) begin
         if (!in_rsp) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_rsp: got data 0x%0h err %0b with no request outstanding", RspData, RspErr);
               cur.name = "unexpected";
               cur.data = RspData;
            end else begin
               cur = sb.pop_front();
               check({cur.name, "_data"}, 32'(RspData), 32'(cur.data));
               check({cur.name, "_err"}, 32'(RspErr), 32'(cur.err));
               check({cur.name, "_edge"}, 32'(cyc), 32'(cur.at_edge));
            end
            in_rsp = 1'b1;
         end else begin
            check({cur.name, "_hold"}, 32'(RspData), 32'(cur.data));
         end
         if (RspReady) in_rsp = 1'b0;
      end
   end

   task automatic do_req(input string name, input logic [2:0] cmd, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ed, input logic ee, input int n, input bit expect_rsp);
      exp_t e;
      int   k;
      @(negedge Clk);
      ReqCmd = cmd; ReqAluOp = op; ReqA = a; ReqB = b; ReqValid = 1'b1;
      k = 0;
      while (!ReqReady && k < 200) begin
         @(negedge Clk);
         k++;
      end
      if (!ReqReady) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_accept: ReqReady stayed 0, required 1 within 200 cycles", name);
         ReqValid = 1'b0;
         return;
      end
      if (expect_rsp) begin
         e.data = ed; e.err = ee; e.at_edge = cyc + 1 + n; e.name = name;
         sb.push_back(e);
      end
      @(posedge Clk);
      #1;
      // Scramble request fields after acceptance; the DUT must have latched them.
      ReqValid = 1'b0; ReqA = ~a; ReqB = ~b; ReqCmd = cmd ^ 3'd3; ReqAluOp = ~op;
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while ((sb.size() != 0 || in_rsp || !ReqReady) && k < 200) begin
         @(negedge Clk);
         k++;
      end
      if (sb.size() != 0 || !ReqReady) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_drain: %0d responses outstanding, ReqReady=%0b, required 0 and 1", name, sb.size(), ReqReady);
         sb.delete();
      end
   endtask

   initial begin
      int k;
      Reset = 1'b0; ReqValid = 1'b0; ReqCmd = '0; ReqAluOp = '0; ReqA = '0; ReqB = '0; RspReady = 1'b1;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check("rst_rspvalid", 32'(RspValid), 32'd0);
      check("rst_reqready", 32'(ReqReady), 32'd0);
      check("rst_aluop", 32'(AluOp), 32'd0);
      check("rst_alua", 32'(AluA), 32'd0);
      check("rst_alub", 32'(AluB), 32'd0);
      check("rst_rspdata", 32'(RspData), 32'd0);
      check("rst_rsperr", 32'(RspErr), 32'd0);
      #2 Reset = 1'b1;
      @(negedge Clk);
      check("post_rst_reqready", 32'(ReqReady), 32'd1);
      check("post_rst_rspvalid", 32'(RspValid), 32'd0);
      check("post_rst_alu", 32'({AluOp, AluA, AluB}), 32'd0);

      do_req("single_add", C_SINGLE, OP_ADD, 8'hF0, 8'h20, 8'h10, 1'b0, 1, 1'b1);  drain("single_add");
      do_req("single_sub", C_SINGLE, OP_SUB, 8'h10, 8'h20, 8'hF0, 1'b0, 1, 1'b1);  drain("single_sub");
      do_req("single_and", C_SINGLE, OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1, 1'b1);  drain("single_and");
      do_req("shl3",       C_SHL,    OP_OR,  8'h81, 8'hFB, 8'h08, 1'b0, 3, 1'b1);  drain("shl3");
      do_req("shr7",       C_SHR,    OP_OR,  8'h80, 8'h07, 8'h01, 1'b0, 7, 1'b1);  drain("shr7");
      do_req("shl0",       C_SHL,    OP_OR,  8'h5A, 8'h00, 8'h5A, 1'b0, 0, 1'b1);  drain("shl0");
      do_req("mul13x11",   C_MUL,    OP_OR,  8'd13, 8'd11, 8'h8F, 1'b0, 19, 1'b1); drain("mul13x11");
      do_req("mul20x20",   C_MUL,    OP_OR,  8'd20, 8'd20, 8'h90, 1'b0, 18, 1'b1); drain("mul20x20");
      do_req("mulFFxFF",   C_MUL,    OP_OR,  8'hFF, 8'hFF, 8'h01, 1'b0, 24, 1'b1); drain("mulFFxFF");
      do_req("mul0x37",    C_MUL,    OP_OR,  8'h00, 8'h37, 8'h00, 1'b0, 21, 1'b1); drain("mul0x37");
      do_req("rsvd5",      3'd5,     OP_ADD, 8'h12, 8'h34, 8'h00, 1'b1, 0, 1'b1);  drain("rsvd5");
      do_req("rsvd7",      3'd7,     OP_ADD, 8'hAB, 8'hCD, 8'h00, 1'b1, 0, 1'b1);  drain("rsvd7");

      // Backpressure: response must stay put and a second request must wait.
      RspReady = 1'b0;
      do_req("bp_xor", C_SINGLE, OP_XOR, 8'h3C, 8'h0F, 8'h33, 1'b0, 1, 1'b1);
      k = 0;
      while (!RspValid && k < 50) begin
         @(negedge Clk);
         k++;
      end
      ReqCmd = C_SINGLE; ReqAluOp = OP_ADD; ReqA = 8'h01; ReqB = 8'h02; ReqValid = 1'b1;
      repeat (5) begin
         @(negedge Clk);
         check("bp_reqready", 32'(ReqReady), 32'd0);
         check("bp_rspvalid", 32'(RspValid), 32'd1);
         check("bp_alu_idle", 32'({AluOp, AluA, AluB}), 32'd0);
      end
      ReqValid = 1'b0;
      RspReady = 1'b1;
      drain("bp_xor");
      do_req("bp_second", C_SINGLE, OP_ADD, 8'h01, 8'h02, 8'h03, 1'b0, 1, 1'b1); drain("bp_second");

      // Reset in the middle of a multiply drops the command without a response.
      do_req("rst_mul", C_MUL, OP_OR, 8'd13, 8'd11, 8'h00, 1'b0, 19, 1'b0);
      repeat (5) @(negedge Clk);
      Reset = 1'b0;
      #1;
      check("midrst_rspvalid", 32'(RspValid), 32'd0);
      check("midrst_reqready", 32'(ReqReady), 32'd0);
      check("midrst_alu", 32'({AluOp, AluA, AluB}), 32'd0);
      @(negedge Clk);
      #2 Reset = 1'b1;
      @(negedge Clk);
      check("midrst_post_reqready", 32'(ReqReady), 32'd1);
      repeat (25) @(negedge Clk);
      check("midrst_quiet_rspvalid", 32'(RspValid), 32'd0);
      do_req("mul_after_rst", C_MUL, OP_OR, 8'd7, 8'd9, 8'd63, 1'b0, 18, 1'b1); drain("mul_after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
